// File: rtl/pe_cluster_sequencer_if.sv
// Purpose : control/status bundle between the PE cluster sequencer and the cluster datapath.
// Latency : n/a (wires only).
// Backpressure: none; done inputs are levels, edge-qualified inside the sequencer.
// master = sequencer side; slave = cluster / host side.
interface pe_cluster_sequencer_if;
    logic       run;
    logic       abort;
    logic       load_done;
    logic       compute_done;
    logic       load_spad_ctrl_wght;
    logic       load_spad_ctrl_iact;
    logic       start_pe;
    logic [7:0] iter_idx;
    logic       iter_valid;
    logic       busy;
    logic       run_done;
    logic       err;

    modport master (
        input  run, abort, load_done, compute_done,
        output load_spad_ctrl_wght, load_spad_ctrl_iact, start_pe,
        output iter_idx, iter_valid, busy, run_done, err
    );

    modport slave (
        output run, abort, load_done, compute_done,
        input  load_spad_ctrl_wght, load_spad_ctrl_iact, start_pe,
        input  iter_idx, iter_valid, busy, run_done, err
    );
endinterface

// File: rtl/pe_cluster_sequencer.sv
// Purpose : sequences weight load, iact load and NUM_ITER compute passes for one PE cluster.
// Latency : run -> load_spad_ctrl_wght 1 cycle; compute_done rise -> iter_valid 1 cycle.
// Backpressure: waits only on rising edges of load_done/compute_done; watchdog forces ERR.
// Ports: clk, reset (async active-low), bus (master modport): run/abort/load_done/compute_done in;
//        load/start strobes, iter_idx, iter_valid, busy, run_done, err out (all registered).
module pe_cluster_sequencer #(
    parameter int NUM_ITER    = 3,
    parameter int CTRL_PULSE  = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    pe_cluster_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_WAIT_W, S_GAP_A, S_LOAD_A, S_WAIT_A,
        S_GAP_C, S_START, S_WAIT_C, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] PULSE_LAST = 16'(CTRL_PULSE - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WDOG_LAST  = 16'(WDOG_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_ITER - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  iter_idx;
    logic        load_done_q, compute_done_q;
    logic        ld_rise, cd_rise;
    logic        iv_nxt, rd_nxt;
    logic        wght_r, iact_r, start_r, busy_r, err_r, iv_r, rd_r;

    assign ld_rise = bus.load_done & ~load_done_q;
    assign cd_rise = bus.compute_done & ~compute_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            load_done_q    <= bus.load_done;
            compute_done_q <= bus.compute_done;
        end
    end

    always_comb begin
        state_nxt = state;
        iv_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        case (state)
            S_IDLE:   if (bus.run) state_nxt = S_LOAD_W;
            S_LOAD_W: if (cnt == PULSE_LAST) state_nxt = S_WAIT_W;
            S_WAIT_W: begin
                if (ld_rise)                state_nxt = (GAP_CYCLES == 0) ? S_LOAD_A : S_GAP_A;
                else if (cnt == WDOG_LAST)  state_nxt = S_ERR;
            end
            S_GAP_A:  if (cnt == GAP_LAST) state_nxt = S_LOAD_A;
            S_LOAD_A: if (cnt == PULSE_LAST) state_nxt = S_WAIT_A;
            S_WAIT_A: begin
                if (ld_rise)                state_nxt = (GAP_CYCLES == 0) ? S_START : S_GAP_C;
                else if (cnt == WDOG_LAST)  state_nxt = S_ERR;
            end
            S_GAP_C:  if (cnt == GAP_LAST) state_nxt = S_START;
            S_START:  if (cnt == PULSE_LAST) state_nxt = S_WAIT_C;
            S_WAIT_C: begin
                // The edge is checked first so it beats a simultaneous watchdog expiry.
                if (cd_rise) begin
                    iv_nxt = 1'b1;
                    if (iter_idx == LAST_IDX) state_nxt = S_DONE;
                    else                      state_nxt = (GAP_CYCLES == 0) ? S_START : S_GAP_C;
                end else if (cnt == WDOG_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                rd_nxt    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR:    if (bus.run) state_nxt = S_LOAD_W;
            default:  state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = S_IDLE;
            iv_nxt    = 1'b0;
            rd_nxt    = 1'b0;
        end
        // One shared counter: pulse width, gap length and watchdog, restarted on every state change.
        if (state_nxt != state || state == S_IDLE || state == S_ERR) cnt_nxt = '0;
        else                                                         cnt_nxt = cnt + 16'd1;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wght_r   <= 1'b0;
            iact_r   <= 1'b0;
            start_r  <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            iv_r     <= 1'b0;
            rd_r     <= 1'b0;
            iter_idx <= '0;
        end else begin
            wght_r  <= (state_nxt == S_LOAD_W);
            iact_r  <= (state_nxt == S_LOAD_A);
            start_r <= (state_nxt == S_START);
            busy_r  <= !(state_nxt == S_IDLE || state_nxt == S_DONE || state_nxt == S_ERR);
            err_r   <= (state_nxt == S_ERR);
            iv_r    <= iv_nxt;
            rd_r    <= rd_nxt;
            // iter_idx advances one cycle after the edge so iter_valid reports the finished pass.
            if (bus.abort)
                iter_idx <= '0;
            else if ((state == S_IDLE || state == S_ERR) && bus.run)
                iter_idx <= '0;
            else if (iv_r && iter_idx != LAST_IDX)
                iter_idx <= iter_idx + 8'd1;
        end
    end

    assign bus.load_spad_ctrl_wght = wght_r;
    assign bus.load_spad_ctrl_iact = iact_r;
    assign bus.start_pe            = start_r;
    assign bus.iter_idx            = iter_idx;
    assign bus.iter_valid          = iv_r;
    assign bus.busy                = busy_r;
    assign bus.run_done            = rd_r;
    assign bus.err                 = err_r;
endmodule

// File: tb/tb_pe_cluster_sequencer.sv
module tb_pe_cluster_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    localparam int N     = 3;
    localparam int PULSE = 2;
    localparam int GAP   = 4;
    localparam int WDOG  = 50;

    localparam int EV_W = 0, EV_A = 1, EV_S = 2, EV_IV = 3, EV_RD = 4, EV_ERR = 5;

    pe_cluster_sequencer_if bus_m ();
    pe_cluster_sequencer_if bus_s ();

    pe_cluster_sequencer #(.NUM_ITER(N), .CTRL_PULSE(PULSE), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG))
        dut_m (.clk(clk), .reset(reset), .bus(bus_m));
    pe_cluster_sequencer #(.NUM_ITER(1), .CTRL_PULSE(1), .GAP_CYCLES(0), .WDOG_CYCLES(WDOG))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  wcnt[3];
    int  err_q;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int osig(input int k);
        case (k)
            0:       return int'(bus_m.load_spad_ctrl_wght);
            1:       return int'(bus_m.load_spad_ctrl_iact);
            2:       return int'(bus_m.start_pe);
            3:       return int'(bus_m.iter_valid);
            4:       return int'(bus_m.run_done);
            5:       return int'(bus_m.err);
            default: return int'(bus_m.busy);
        endcase
    endfunction

    function automatic int outs_m();
        return int'({bus_m.load_spad_ctrl_wght, bus_m.load_spad_ctrl_iact, bus_m.start_pe,
                     bus_m.iter_idx, bus_m.iter_valid, bus_m.busy, bus_m.run_done, bus_m.err});
    endfunction

    function automatic int outs_s();
        return int'({bus_s.load_spad_ctrl_wght, bus_s.load_spad_ctrl_iact, bus_s.start_pe,
                     bus_s.iter_idx, bus_s.iter_valid, bus_s.busy, bus_s.run_done, bus_s.err});
    endfunction

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed output event is matched against the expected queue.
    task automatic observed(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_event_kind%0d", kind), 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk($sformatf("sb_val_kind%0d", e.kind), val, e.val);
        end
    endtask

    initial begin : monitor
        for (int k = 0; k < 3; k++) wcnt[k] = 0;
        err_q = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (osig(k) != 0) begin
                    wcnt[k]++;
                end else if (wcnt[k] != 0) begin
                    observed(k, wcnt[k]);
                    wcnt[k] = 0;
                end
            end
            if (bus_m.iter_valid) observed(EV_IV, int'(bus_m.iter_idx));
            if (bus_m.run_done)   observed(EV_RD, 0);
            if (bus_m.err && err_q == 0) observed(EV_ERR, 0);
            err_q = int'(bus_m.err);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_lvl(input int k, input int lvl, input string name, output int n);
        n = 0;
        while (osig(k) != lvl && n < 200) begin
            step();
            n++;
        end
        chk(name, osig(k), lvl);
    endtask

    // PE model: produce a fresh rising edge on load_done (which=0) or compute_done (which=1).
    task automatic drive_done(input bit which, input bit keep);
        if (which == 1'b0) begin
            if (bus_m.load_done) begin bus_m.load_done = 1'b0; steps(2); end
            bus_m.load_done = 1'b1;
            step();
            if (!keep) bus_m.load_done = 1'b0;
        end else begin
            if (bus_m.compute_done) begin bus_m.compute_done = 1'b0; steps(2); end
            bus_m.compute_done = 1'b1;
            step();
            if (!keep) bus_m.compute_done = 1'b0;
        end
    endtask

    task automatic do_run(input bit stale_ld, input bit stale_cd, input int abort_pass, input bit wdog);
        int n;
        int seen;
        bit stop;
        stop = 1'b0;
        push(EV_W, PULSE);
        push(EV_A, PULSE);
        for (int p = 0; p < N; p++) begin
            if (!stop) begin
                push(EV_S, PULSE);
                if (wdog) begin
                    push(EV_ERR, 0);
                    stop = 1'b1;
                end else if (p == abort_pass) begin
                    stop = 1'b1;
                end else begin
                    push(EV_IV, p);
                end
            end
        end
        if (!stop) push(EV_RD, 0);

        bus_m.load_done    = 1'b0;
        bus_m.compute_done = 1'b0;
        bus_m.run = 1'b1;
        step();
        bus_m.run = 1'b0;
        chk("run_to_wght", osig(0), 1);
        chk("busy_in_run", int'(bus_m.busy), 1);
        chk("err_cleared", int'(bus_m.err), 0);
        chk("idx_at_start", int'(bus_m.iter_idx), 0);

        wait_lvl(0, 0, "wght_fall", n);
        steps($urandom_range(3, 25));
        drive_done(1'b0, stale_ld);
        wait_lvl(1, 1, "iact_rise", n);
        chk("ld_to_iact", n + 1, GAP + 1);
        wait_lvl(1, 0, "iact_fall", n);
        if (stale_ld) begin
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (bus_m.start_pe) seen = 1;
            end
            chk("stale_load_done_ignored", seen, 0);
        end else begin
            steps($urandom_range(3, 25));
        end
        drive_done(1'b0, 1'b0);
        wait_lvl(2, 1, "start_rise", n);
        chk("ld_to_start", n + 1, GAP + 1);

        for (int p = 0; p < N; p++) begin
            wait_lvl(2, 0, "start_fall", n);
            if (wdog) begin
                wait_lvl(5, 1, "err_rise", n);
                chk("wdog_latency", n, WDOG);
                chk("err_start_low", int'(bus_m.start_pe), 0);
                chk("err_busy_low", int'(bus_m.busy), 0);
                return;
            end
            if (p == abort_pass) begin
                steps($urandom_range(1, 10));
                bus_m.abort = 1'b1;
                step();
                bus_m.abort = 1'b0;
                chk("abort_busy", int'(bus_m.busy), 0);
                chk("abort_idx", int'(bus_m.iter_idx), 0);
                bus_m.compute_done = 1'b1;
                steps(3);
                bus_m.compute_done = 1'b0;
                steps(20);
                return;
            end
            if (stale_cd && p > 0) begin
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    step();
                    if (bus_m.iter_valid) seen = 1;
                end
                chk("stale_compute_done_ignored", seen, 0);
            end else begin
                steps($urandom_range(3, 25));
            end
            drive_done(1'b1, stale_cd && (p < N - 1));
            chk("cd_to_iv", int'(bus_m.iter_valid), 1);
            chk("iv_idx", int'(bus_m.iter_idx), p);
            if (p < N - 1) begin
                wait_lvl(2, 1, "start_rise", n);
                chk("cd_to_start", n + 1, GAP + 1);
            end
        end
        step();
        chk("iv_to_run_done", int'(bus_m.run_done), 1);
        chk("busy_after_done", int'(bus_m.busy), 0);
        step();
        chk("run_done_one_cycle", int'(bus_m.run_done), 0);
    endtask

    task automatic drained();
        step();
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin : stim
        reset = 1'b0;
        bus_m.run = 1'b1;  bus_m.abort = 1'b0;  bus_m.load_done = 1'b0;  bus_m.compute_done = 1'b0;
        bus_s.run = 1'b0;  bus_s.abort = 1'b0;  bus_s.load_done = 1'b0;  bus_s.compute_done = 1'b0;
        steps(3);
        chk("reset_outputs_main", outs_m(), 0);
        chk("reset_outputs_small", outs_s(), 0);
        bus_m.run = 1'b0;
        reset = 1'b1;
        steps(5);
        chk("idle_after_reset", outs_m(), 0);

        bus_m.run = 1'b1;
        bus_m.abort = 1'b1;
        step();
        bus_m.run = 1'b0;
        bus_m.abort = 1'b0;
        chk("abort_beats_run", outs_m(), 0);
        step();

        do_run(1'b0, 1'b0, -1, 1'b0);  drained();
        do_run(1'b0, 1'b0, -1, 1'b0);  drained();
        do_run(1'b1, 1'b1, -1, 1'b0);  drained();
        do_run(1'b0, 1'b0, -1, 1'b1);  drained();
        do_run(1'b0, 1'b0, -1, 1'b0);  drained();
        do_run(1'b0, 1'b0, 1, 1'b0);   drained();
        do_run(1'b0, 1'b0, -1, 1'b0);  drained();

        // Single-pass, no-gap, 1-cycle-pulse instance.
        bus_s.run = 1'b1;
        step();
        bus_s.run = 1'b0;
        chk("s_run_to_wght", int'(bus_s.load_spad_ctrl_wght), 1);
        step();
        chk("s_wght_width1", int'(bus_s.load_spad_ctrl_wght), 0);
        chk("s_busy_wait", int'(bus_s.busy), 1);
        steps(3);
        bus_s.load_done = 1'b1;
        step();
        bus_s.load_done = 1'b0;
        chk("s_iact_after_ld", int'(bus_s.load_spad_ctrl_iact), 1);
        step();
        chk("s_iact_width1", int'(bus_s.load_spad_ctrl_iact), 0);
        steps(2);
        bus_s.load_done = 1'b1;
        step();
        bus_s.load_done = 1'b0;
        chk("s_start_after_ld", int'(bus_s.start_pe), 1);
        step();
        chk("s_start_width1", int'(bus_s.start_pe), 0);
        steps(2);
        bus_s.compute_done = 1'b1;
        step();
        bus_s.compute_done = 1'b0;
        chk("s_iter_valid", int'(bus_s.iter_valid), 1);
        chk("s_iter_idx", int'(bus_s.iter_idx), 0);
        step();
        chk("s_iv_width1", int'(bus_s.iter_valid), 0);
        chk("s_run_done", int'(bus_s.run_done), 1);
        step();
        chk("s_run_done_width1", int'(bus_s.run_done), 0);
        chk("s_idle_busy", int'(bus_s.busy), 0);

        drained();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
